controle_tempo: RTL and testbench

Cook-time controller for the microwave. It sequences the keypad input path: it captures BCD digits into a four-digit MM:SS register during programming, then drives the input path's `enablen` select so that `pgt_1Hz` carries the 1 Hz tick, and counts the time down while the magnetron is enabled. It handles the start, stop/pause, clear and door-interlock commands. It sits between the input-encoding block and the display/magnetron drivers.

---
 rtl/controle_tempo_if.sv | 28 ++
 rtl/controle_tempo.sv | 135 +++++++++++++
 tb/tb_controle_tempo.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_tempo_if.sv
// Keypad-path, command and display bundle of the cook-time controller.
// slave = controller side, master = stimulus/encoder side.
interface controle_tempo_if;
  logic [3:0] bcd_in;
  logic       pgt_1Hz;
  logic       start_n;
  logic       stop_n;
  logic       clear_n;
  logic       door_closed;
  logic       enablen;
  logic       mag_on;
  logic       done;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] state;

  modport slave (
    input  bcd_in, pgt_1Hz, start_n, stop_n, clear_n, door_closed,
    output enablen, mag_on, done, min_t, min_u, sec_t, sec_u, state
  );

  modport master (
    output bcd_in, pgt_1Hz, start_n, stop_n, clear_n, door_closed,
    input  enablen, mag_on, done, min_t, min_u, sec_t, sec_u, state
  );
endinterface

// File: rtl/controle_tempo.sv
// Microwave cook-time controller: MM:SS entry, 1 Hz BCD countdown, start/stop/clear/door handling.
// Events act on the edge they are detected; outputs change one cycle after the input edge.
module controle_tempo (
  input  logic              clk100Hz,
  input  logic              clr,
  controle_tempo_if.slave   bus
);

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_min_t, r_min_u, r_sec_t, r_sec_u;
  logic [3:0] w_min_t_nxt, w_min_u_nxt, w_sec_t_nxt, w_sec_u_nxt;
  logic       r_pgt_prev, r_start_prev, r_stop_prev, r_clear_prev;

  logic w_pgt_rise, w_press_start, w_press_stop, w_press_clear;
  logic w_time_zero;
  logic w_b0, w_b1, w_b2;
  logic [3:0] w_dec_min_t, w_dec_min_u, w_dec_sec_t, w_dec_sec_u;
  logic w_dec_zero;

  assign w_pgt_rise    = bus.pgt_1Hz & ~r_pgt_prev;
  assign w_press_start = ~bus.start_n & r_start_prev;
  assign w_press_stop  = ~bus.stop_n  & r_stop_prev;
  assign w_press_clear = ~bus.clear_n & r_clear_prev;

  assign w_time_zero = (r_min_t == 4'd0) && (r_min_u == 4'd0) &&
                       (r_sec_t == 4'd0) && (r_sec_u == 4'd0);

  // Borrow chain: seconds units wrap to 9, seconds tens to 5, minute units to 9.
  assign w_b0        = (r_sec_u == 4'd0);
  assign w_dec_sec_u = w_b0 ? 4'd9 : r_sec_u - 4'd1;
  assign w_b1        = w_b0 && (r_sec_t == 4'd0);
  assign w_dec_sec_t = w_b0 ? ((r_sec_t == 4'd0) ? 4'd5 : r_sec_t - 4'd1) : r_sec_t;
  assign w_b2        = w_b1 && (r_min_u == 4'd0);
  assign w_dec_min_u = w_b1 ? ((r_min_u == 4'd0) ? 4'd9 : r_min_u - 4'd1) : r_min_u;
  assign w_dec_min_t = w_b2 ? r_min_t - 4'd1 : r_min_t;
  assign w_dec_zero  = (w_dec_min_t == 4'd0) && (w_dec_min_u == 4'd0) &&
                       (w_dec_sec_t == 4'd0) && (w_dec_sec_u == 4'd0);

  always_ff @(posedge clk100Hz) begin
    if (clr) begin
      r_state      <= SETUP;
      r_min_t      <= 4'd0;
      r_min_u      <= 4'd0;
      r_sec_t      <= 4'd0;
      r_sec_u      <= 4'd0;
      r_pgt_prev   <= 1'b0;
      r_start_prev <= 1'b1;
      r_stop_prev  <= 1'b1;
      r_clear_prev <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_min_t      <= w_min_t_nxt;
      r_min_u      <= w_min_u_nxt;
      r_sec_t      <= w_sec_t_nxt;
      r_sec_u      <= w_sec_u_nxt;
      r_pgt_prev   <= bus.pgt_1Hz;
      r_start_prev <= bus.start_n;
      r_stop_prev  <= bus.stop_n;
      r_clear_prev <= bus.clear_n;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_min_t_nxt = r_min_t;
    w_min_u_nxt = r_min_u;
    w_sec_t_nxt = r_sec_t;
    w_sec_u_nxt = r_sec_u;
    case (r_state)
      SETUP: begin
        if (w_press_clear) begin
          w_min_t_nxt = 4'd0;
          w_min_u_nxt = 4'd0;
          w_sec_t_nxt = 4'd0;
          w_sec_u_nxt = 4'd0;
        end else if (w_press_start && bus.door_closed && !w_time_zero) begin
          w_state_nxt = COOK;
        end else if (w_pgt_rise && (bus.bcd_in <= 4'd9)) begin
          w_min_t_nxt = r_min_u;
          w_min_u_nxt = r_sec_t;
          w_sec_t_nxt = r_sec_u;
          w_sec_u_nxt = bus.bcd_in;
        end
      end
      COOK: begin
        // Door open or stop beats a coincident tick; the tick is dropped.
        if (!bus.door_closed || w_press_stop) begin
          w_state_nxt = PAUSED;
        end else if (w_pgt_rise) begin
          w_min_t_nxt = w_dec_min_t;
          w_min_u_nxt = w_dec_min_u;
          w_sec_t_nxt = w_dec_sec_t;
          w_sec_u_nxt = w_dec_sec_u;
          if (w_dec_zero) w_state_nxt = DONE;
        end
      end
      PAUSED: begin
        if (w_press_stop || w_press_clear) begin
          w_state_nxt = SETUP;
          w_min_t_nxt = 4'd0;
          w_min_u_nxt = 4'd0;
          w_sec_t_nxt = 4'd0;
          w_sec_u_nxt = 4'd0;
        end else if (w_press_start && bus.door_closed) begin
          w_state_nxt = COOK;
        end
      end
      default: begin
        w_min_t_nxt = 4'd0;
        w_min_u_nxt = 4'd0;
        w_sec_t_nxt = 4'd0;
        w_sec_u_nxt = 4'd0;
        if (w_press_start || w_press_stop || w_press_clear || !bus.door_closed)
          w_state_nxt = SETUP;
      end
    endcase
  end

  assign bus.enablen = (r_state != COOK);
  assign bus.mag_on  = (r_state == COOK);
  assign bus.done    = (r_state == DONE);
  assign bus.state   = r_state;
  assign bus.min_t   = r_min_t;
  assign bus.min_u   = r_min_u;
  assign bus.sec_t   = r_sec_t;
  assign bus.sec_u   = r_sec_u;

endmodule

// File: tb/tb_controle_tempo.sv
// Bench for controle_tempo: directed scenarios plus a random run against a minutes/seconds model.
module tb_controle_tempo;
  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  controle_tempo_if bus();

  controle_tempo dut (
    .clk100Hz (clk),
    .clr      (clr),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference model: mode 0..3, minutes and seconds as plain integers.
  int ms = 0, mm = 0, ss = 0;
  bit mp_pgt = 0, mp_start = 1, mp_stop = 1, mp_clear = 1;

  task automatic model_update();
    bit pr, st, sp, cl, dr;
    int v;
    if (clr) begin
      ms = 0; mm = 0; ss = 0;
      mp_pgt = 0; mp_start = 1; mp_stop = 1; mp_clear = 1;
      return;
    end
    pr = bus.pgt_1Hz && !mp_pgt;
    st = !bus.start_n && mp_start;
    sp = !bus.stop_n && mp_stop;
    cl = !bus.clear_n && mp_clear;
    dr = bus.door_closed;
    case (ms)
      0: if (cl) begin mm = 0; ss = 0; end
         else if (st && dr && (mm + ss) != 0) ms = 1;
         else if (pr && bus.bcd_in <= 9) begin
           v = ((mm * 100 + ss) * 10 + int'(bus.bcd_in)) % 10000;
           mm = v / 100; ss = v % 100;
         end
      1: if (!dr || sp) ms = 2;
         else if (pr) begin
           if (ss > 0) ss = ss - 1;
           else begin mm = mm - 1; ss = 59; end
           if (mm == 0 && ss == 0) ms = 3;
         end
      2: if (sp || cl) begin ms = 0; mm = 0; ss = 0; end
         else if (st && dr) ms = 1;
      default: begin
        mm = 0; ss = 0;
        if (st || sp || cl || !dr) ms = 0;
      end
    endcase
    mp_pgt = bus.pgt_1Hz; mp_start = bus.start_n;
    mp_stop = bus.stop_n; mp_clear = bus.clear_n;
  endtask

  function automatic logic [20:0] exp_vec();
    return {2'(ms), (ms != 1), (ms == 1), (ms == 3),
            4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.state, bus.enablen, bus.mag_on, bus.done,
            bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  function automatic logic [15:0] digits();
    return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic strobe(input logic [3:0] d, input int hold);
    bus.bcd_in = d;
    bus.pgt_1Hz = 1'b1;
    repeat (hold) cyc();
    bus.pgt_1Hz = 1'b0;
    cyc();
  endtask

  task automatic tick();
    strobe(4'($urandom_range(0, 15)), $urandom_range(1, 3));
  endtask

  task automatic press(input int which);
    case (which)
      0: bus.start_n = 1'b0;
      1: bus.stop_n  = 1'b0;
      default: bus.clear_n = 1'b0;
    endcase
    cyc();
    bus.start_n = 1'b1; bus.stop_n = 1'b1; bus.clear_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    cyc(); cyc();
    clr = 1'b0;
    if (obs() !== {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL reset got=%h exp=%h", obs(), {2'd0, 3'b100, 16'h0000});
    end
    total++;
  endtask

  task automatic test_entry();
    strobe(4'd1, $urandom_range(1, 4));
    strobe(4'd3, $urandom_range(1, 4));
    strobe(4'd0, $urandom_range(1, 4));
    if (digits() !== 16'h0130) begin
      bad++; $display("FAIL entry_0130 got=%h exp=0130", digits());
    end
    total++;
    strobe(4'd12, 2);
    if (obs() !== exp_vec() || digits() !== 16'h0130) begin
      bad++; $display("FAIL entry_ignore12 got=%h exp=%h", obs(), exp_vec());
    end
    total++;
  endtask

  task automatic test_cook();
    press(0);
    if (obs() !== exp_vec() || bus.mag_on !== 1'b1 || bus.enablen !== 1'b0) begin
      bad++; $display("FAIL cook_start got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    tick();
    if (digits() !== 16'h0129) begin
      bad++; $display("FAIL cook_0129 got=%h exp=0129", digits());
    end
    total++;
    repeat (29) tick();
    if (obs() !== exp_vec() || digits() !== 16'h0100) begin
      bad++; $display("FAIL cook_0100 got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    tick();
    if (digits() !== 16'h0059 || bus.state !== 2'd1) begin
      bad++; $display("FAIL cook_wrap got=%h exp=1_0059", {bus.state, digits()});
    end
    total++;
  endtask

  task automatic test_done();
    press(1);
    if (obs() !== exp_vec() || bus.state !== 2'd2) begin
      bad++; $display("FAIL stop_pause got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    press(1);
    if (obs() !== exp_vec() || digits() !== 16'h0000) begin
      bad++; $display("FAIL stop_setup got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    strobe(4'd2, 1);
    press(0);
    tick();
    if (digits() !== 16'h0001 || bus.state !== 2'd1) begin
      bad++; $display("FAIL done_0001 got=%h exp=1_0001", {bus.state, digits()});
    end
    total++;
    tick();
    if (obs() !== {2'd3, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL done_reached got=%h exp=%h", obs(), {2'd3, 3'b101, 16'h0000});
    end
    total++;
    press(1);
    if (obs() !== exp_vec() || bus.state !== 2'd0) begin
      bad++; $display("FAIL done_exit got=%h exp=%h", obs(), exp_vec());
    end
    total++;
  endtask

  task automatic test_pause();
    strobe(4'd4, 1);
    strobe(4'd5, 2);
    press(0);
    bus.door_closed = 1'b0;
    cyc();
    if (bus.state !== 2'd2 || digits() !== 16'h0045 || bus.mag_on !== 1'b0) begin
      bad++; $display("FAIL door_pause got=%h exp=2_0045", {bus.state, digits()});
    end
    total++;
    repeat (3) tick();
    press(0);
    if (obs() !== exp_vec() || bus.state !== 2'd2 || digits() !== 16'h0045) begin
      bad++; $display("FAIL pause_hold got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    bus.door_closed = 1'b1;
    press(0);
    tick();
    if (obs() !== exp_vec() || digits() !== 16'h0044) begin
      bad++; $display("FAIL resume got=%h exp=%h", obs(), exp_vec());
    end
    total++;
  endtask

  task automatic test_setup_guard();
    clr = 1'b1; cyc(); clr = 1'b0;
    press(0);
    if (bus.state !== 2'd0) begin
      bad++; $display("FAIL start_zero got=%0d exp=0", bus.state);
    end
    total++;
    strobe(4'd9, 1); strobe(4'd3, 1); strobe(4'd0, 1);
    bus.door_closed = 1'b0;
    press(0);
    if (obs() !== exp_vec() || bus.state !== 2'd0 || digits() !== 16'h0930) begin
      bad++; $display("FAIL start_door_open got=%h exp=%h", obs(), exp_vec());
    end
    total++;
    bus.door_closed = 1'b1;
    press(2);
    if (digits() !== 16'h0000) begin
      bad++; $display("FAIL clear got=%h exp=0000", digits());
    end
    total++;
  endtask

  task automatic test_held();
    strobe(4'd7, 20);
    if (obs() !== exp_vec() || digits() !== 16'h0007) begin
      bad++; $display("FAIL held_strobe got=%h exp=%h", obs(), exp_vec());
    end
    total++;
  endtask

  task automatic test_clr();
    press(2);
    strobe(4'd1, 1); strobe(4'd2, 1); strobe(4'd0, 1); strobe(4'd0, 1);
    press(0);
    tick();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    if (obs() !== {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL clr_cook got=%h exp=%h", obs(), {2'd0, 3'b100, 16'h0000});
    end
    total++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      clr             = ($urandom_range(0, 199) == 0);
      bus.door_closed = ($urandom_range(0, 15) != 0);
      bus.start_n     = ($urandom_range(0, 7) != 0);
      bus.stop_n      = ($urandom_range(0, 29) != 0);
      bus.clear_n     = ($urandom_range(0, 39) != 0);
      bus.pgt_1Hz     = ($urandom_range(0, 2) == 0);
      bus.bcd_in      = 4'($urandom_range(0, 15));
      cyc();
      if (obs() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      total++;
    end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    bus.bcd_in = 4'd0; bus.pgt_1Hz = 1'b0;
    bus.start_n = 1'b1; bus.stop_n = 1'b1; bus.clear_n = 1'b1;
    bus.door_closed = 1'b1;
    test_reset();
    test_entry();
    test_cook();
    test_done();
    test_pause();
    test_setup_guard();
    test_held();
    test_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
